mtimer_periph: RTL and testbench

- Memory-mapped RISC-V machine timer that sits on the core's data bus, downstream of the core's mem_addr/mem_dout/mem_read_en/mem_write_en/mem_width outputs.
- Holds a 64-bit mtime counter (prescaled) and a 64-bit mtimecmp compare register.
- Drives a registered timer interrupt into the core's interrupt logic.
- Read data is returned combinationally, so it can be OR-ed onto the core's mem_din.

---
 rtl/mtimer_periph_if.sv | 14 +
 rtl/mtimer_periph.sv | 161 ++++++++++++++++
 tb/tb_mtimer_periph.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtimer_periph_if.sv
// Data-bus connection between the core's load/store port and the machine timer.
// The core side drives the strobes; the timer returns read data and an error pulse.
interface mtimer_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        read_en;
    logic        write_en;
    logic [1:0]  width;
    logic        err;

    modport master (output addr, wdata, read_en, write_en, width, input rdata, err);
    modport slave  (input addr, wdata, read_en, write_en, width, output rdata, err);
endinterface

// File: rtl/mtimer_periph.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, registered level interrupt.
// Reads are combinational so rdata can be OR-ed onto the core's load data.
module mtimer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    mtimer_periph_if.slave bus,
    output logic           timer_irq
);
    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_SNAP     = 3'd5;

    logic [63:0]        mtime, mtime_next;
    logic [63:0]        mtimecmp, mtimecmp_next;
    logic               en, en_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic [PRESC_W-1:0] presc_cnt, presc_cnt_next;
    logic [31:0]        snap;
    logic               err;
    logic               irq_next;

    logic               sel, misalign, rd_ok, wr_ok, err_next, snap_load, tick, mtime_wr;
    logic [2:0]         widx;
    logic [1:0]         boff;
    logic [31:0]        ctrl_word, reg_word, wdata_rep, wbits;

    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'd0:    lane_data = {4{d[7:0]}};
            2'd1:    lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] bits);
        merge = (old & ~bits) | (d & bits);
    endfunction

    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] off);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (width)
            2'd0:    read_align = {24'h0, shifted[7:0]};
            2'd1:    read_align = {16'h0, shifted[15:0]};
            default: read_align = shifted;
        endcase
    endfunction

    assign sel  = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign widx = bus.addr[4:2];
    assign boff = bus.addr[1:0];

    always_comb begin
        case (bus.width)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = boff[0];
            2'd2:    misalign = (boff != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign rd_ok     = sel && bus.read_en && !misalign;
    assign wr_ok     = sel && bus.write_en && !misalign;
    assign err_next  = sel && (bus.read_en || bus.write_en) && misalign;
    assign snap_load = rd_ok && (widx == IDX_MTIME_LO);
    assign wdata_rep = lane_data(bus.width, bus.wdata);
    assign wbits     = wr_ok ? lane_bits(lane_mask(bus.width, boff)) : 32'h0;
    assign tick      = en && (presc_cnt == presc);
    assign mtime_wr  = wr_ok && ((widx == IDX_MTIME_LO) || (widx == IDX_MTIME_HI));

    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = en;
        ctrl_word[8 +: PRESC_W] = presc;
    end

    always_comb begin
        case (widx)
            IDX_MTIME_LO: reg_word = mtime[31:0];
            IDX_MTIME_HI: reg_word = mtime[63:32];
            IDX_CMP_LO:   reg_word = mtimecmp[31:0];
            IDX_CMP_HI:   reg_word = mtimecmp[63:32];
            IDX_CTRL:     reg_word = ctrl_word;
            IDX_SNAP:     reg_word = snap;
            default:      reg_word = '0;
        endcase
    end

    // Reads see the pre-edge state, so a simultaneous write still returns the old value.
    assign bus.rdata = rd_ok ? read_align(reg_word, bus.width, boff) : 32'h0;
    assign bus.err   = err;

    always_comb begin
        mtime_next     = mtime;
        mtimecmp_next  = mtimecmp;
        en_next        = en;
        presc_next     = presc;
        presc_cnt_next = presc_cnt;
        if (en) presc_cnt_next = tick ? '0 : presc_cnt + 1'b1;
        // A write to either mtime half suppresses the tick for all 64 bits (no carry leak).
        if (tick && !mtime_wr) mtime_next = mtime + 64'd1;
        if (wr_ok) begin
            case (widx)
                IDX_MTIME_LO: mtime_next[31:0]     = merge(mtime[31:0], wdata_rep, wbits);
                IDX_MTIME_HI: mtime_next[63:32]    = merge(mtime[63:32], wdata_rep, wbits);
                IDX_CMP_LO:   mtimecmp_next[31:0]  = merge(mtimecmp[31:0], wdata_rep, wbits);
                IDX_CMP_HI:   mtimecmp_next[63:32] = merge(mtimecmp[63:32], wdata_rep, wbits);
                IDX_CTRL: begin
                    en_next        = wbits[0] ? wdata_rep[0] : en;
                    presc_next     = (presc & ~wbits[8 +: PRESC_W]) |
                                     (wdata_rep[8 +: PRESC_W] & wbits[8 +: PRESC_W]);
                    presc_cnt_next = '0;
                end
                default: ;
            endcase
        end
        irq_next = (mtime_next >= mtimecmp_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            en        <= 1'b1;
            presc     <= '0;
            presc_cnt <= '0;
            snap      <= 32'h0;
            timer_irq <= 1'b0;
            err       <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            en        <= en_next;
            presc     <= presc_next;
            presc_cnt <= presc_cnt_next;
            if (snap_load) snap <= mtime[63:32];
            timer_irq <= irq_next;
            err       <= err_next;
        end
    end
endmodule

// File: tb/tb_mtimer_periph.sv
// Scenario bench for mtimer_periph: expected read values are queued when a read is driven
// and popped when the combinational response is sampled.
module tb_mtimer_periph;
    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_LO = BASE + 32'h00, A_HI = BASE + 32'h04;
    localparam logic [31:0] A_CLO = BASE + 32'h08, A_CHI = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10, A_SNAP = BASE + 32'h14;

    logic clk;
    logic reset;
    logic timer_irq;
    int   checks;
    int   failures;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    mtimer_periph_if bus ();

    mtimer_periph #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.width = w;
        bus.write_en = 1'b1; bus.read_en = 1'b0;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] w, input logic [31:0] e);
        @(negedge clk);
        bus.addr = a; bus.width = w;
        bus.read_en = 1'b1; bus.write_en = 1'b0;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.width = 2'd2;
        bus.read_en = 1'b0; bus.write_en = 1'b0;
        repeat (3) @(negedge clk);
        rd(A_CHI, 2'd2, 32'hFFFF_FFFF);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_cmp_hi got=%h exp=%h", got, exp); end
        rd(A_SNAP, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_snap got=%h exp=%h", got, exp); end
        checks++;
        if (timer_irq !== 1'b0 || bus.err !== 1'b0) begin
            failures++; $display("FAIL rst_irq_err got=%b%b exp=00", timer_irq, bus.err);
        end
        rd(A_LO, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rst_mtime got=%h exp=%h", got, exp); end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(32'd5);
        #1;
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL mtime_cycle5 got=%0d exp=%0d", got, exp); end
        rd(A_CTRL, 2'd2, 32'h0000_0001);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL ctrl_reset got=%h exp=%h", got, exp); end
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_after_rst got=%b exp=0", timer_irq); end
    endtask

    task automatic test_prescaler;
        do_write(A_CTRL, 32'h0, 2'd2);
        do_write(A_LO, 32'h0, 2'd2);
        do_write(A_HI, 32'h0, 2'd2);
        do_write(A_CTRL, 32'h0000_0301, 2'd2);
        rd(A_LO, 2'd2, 32'd0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL presc_start got=%0d exp=%0d", got, exp); end
        repeat (40) @(posedge clk);
        rd(A_LO, 2'd2, 32'd10);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL presc_40cyc got=%0d exp=%0d", got, exp); end
        rd(A_CTRL, 2'd2, 32'h0000_0301);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL ctrl_readback got=%h exp=%h", got, exp); end
        do_write(A_CTRL, 32'h0, 2'd2);
        rd(A_LO, 2'd2, 32'd10);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL freeze_start got=%0d exp=%0d", got, exp); end
        repeat (20) @(posedge clk);
        rd(A_LO, 2'd2, 32'd10);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL freeze_20cyc got=%0d exp=%0d", got, exp); end
    endtask

    task automatic test_irq;
        logic e_irq;
        do_write(A_CHI, 32'h0, 2'd2);
        do_write(A_CLO, 32'd100, 2'd2);
        do_write(A_HI, 32'h0, 2'd2);
        do_write(A_LO, 32'd90, 2'd2);
        do_write(A_CTRL, 32'h0000_0001, 2'd2);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_at_90 got=%b exp=0", timer_irq); end
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            e_irq = ((90 + i) >= 100);
            checks++;
            if (timer_irq !== e_irq) begin
                failures++; $display("FAIL irq_step%0d got=%b exp=%b", i, timer_irq, e_irq);
            end
        end
        rd(A_LO, 2'd2, 32'd100);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL mtime_at_irq got=%0d exp=%0d", got, exp); end
        do_write(A_CLO, 32'hFFFF_FFFF, 2'd2);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    endtask

    task automatic test_wrap;
        do_write(A_HI, 32'hFFFF_FFFF, 2'd2);
        do_write(A_LO, 32'hFFFF_FFFE, 2'd2);
        rd(A_LO, 2'd2, 32'hFFFF_FFFE);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap_pre_lo got=%h exp=%h", got, exp); end
        rd(A_SNAP, 2'd2, 32'hFFFF_FFFF);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap_pre_snap got=%h exp=%h", got, exp); end
        rd(A_LO, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap_lo got=%h exp=%h", got, exp); end
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL wrap_irq got=%b exp=0", timer_irq); end
        rd(A_SNAP, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap_snap got=%h exp=%h", got, exp); end
    endtask

    task automatic test_lanes;
        do_write(A_CLO, 32'h1122_3344, 2'd2);
        do_write(BASE + 32'h09, 32'h0000_00AB, 2'd0);
        rd(A_CLO, 2'd2, 32'h1122_AB44);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL byte_write got=%h exp=%h", got, exp); end
        rd(BASE + 32'h0A, 2'd1, 32'h0000_1122);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL half_read got=%h exp=%h", got, exp); end
        rd(BASE + 32'h0B, 2'd0, 32'h0000_0011);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL byte_read got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.addr = A_CLO; bus.width = 2'd2; bus.wdata = 32'hCAFE_F00D;
        bus.read_en = 1'b1; bus.write_en = 1'b1;
        exp_q.push_back(32'h1122_AB44);
        #1;
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rw_prewrite got=%h exp=%h", got, exp); end
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        rd(A_CLO, 2'd2, 32'hCAFE_F00D);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL rw_postwrite got=%h exp=%h", got, exp); end
    endtask

    task automatic test_misalign;
        do_write(BASE + 32'h06, 32'hDEAD_BEEF, 2'd2);
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL err_word_pulse got=%b exp=1", bus.err); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL err_word_drop got=%b exp=0", bus.err); end
        rd(A_HI, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL misaligned_no_write got=%h exp=%h", got, exp); end
        rd(BASE + 32'h0B, 2'd1, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL misaligned_rdata got=%h exp=%h", got, exp); end
        do_write(BASE + 32'h0B, 32'h0000_5555, 2'd1);
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL err_half_pulse got=%b exp=1", bus.err); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL err_half_drop got=%b exp=0", bus.err); end
        rd(A_CLO, 2'd2, 32'hCAFE_F00D);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL half_no_write got=%h exp=%h", got, exp); end
        do_write(BASE + 32'h48, 32'h1234_5678, 2'd2);
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL err_outside got=%b exp=0", bus.err); end
        rd(BASE + 32'h48, 2'd2, 32'h0);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL outside_rdata got=%h exp=%h", got, exp); end
        rd(A_CLO, 2'd2, 32'hCAFE_F00D);
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL outside_no_alias got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_midrun;
        do_write(A_CHI, 32'h0, 2'd2);
        do_write(A_CLO, 32'h0, 2'd2);
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_cmp_zero got=%b exp=1", timer_irq); end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", timer_irq); end
        bus.addr = A_CLO; bus.width = 2'd2; bus.read_en = 1'b1; bus.write_en = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        #1;
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL midrst_cmp got=%h exp=%h", got, exp); end
        bus.addr = A_CTRL;
        exp_q.push_back(32'h0000_0001);
        #1;
        got = bus.rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL midrst_ctrl got=%h exp=%h", got, exp); end
        @(negedge clk);
        bus.read_en = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_prescaler();
        test_irq();
        test_wrap();
        test_lanes();
        test_back_to_back();
        test_misalign();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
